// File: rtl/led_sequencer.sv
// led_sequencer: one push-button steps the blinky red/green enables
// through OFF -> RED -> GREEN -> ALT; ALT alternates on a dwell timer.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   btn      raw push-button, active high, asynchronous to clk
//   hold     (LED_SEQ_HOLD_EN only) freeze: drop presses, stop dwell,
//            keep outputs
//   red_en   red enable to blinky (registered)
//   green_en green enable to blinky (registered)
//   mode     current mode: 0 OFF, 1 RED, 2 GREEN, 3 ALT
//   change   one-cycle pulse when the enables update or the mode changes
//
// Build option: define LED_SEQ_HOLD_EN to add the hold input.
module led_sequencer #(
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int DWELL_TICKS    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
`ifdef LED_SEQ_HOLD_EN
  input  logic       hold,
`endif
  output logic       red_en,
  output logic       green_en,
  output logic [1:0] mode,
  output logic       change
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW =
    (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int DW =
    (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic [PW-1:0] PRE_MAX =
    PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] DB_MAX =
    BW'(DEBOUNCE_TICKS - 1);
  localparam logic [DW-1:0] DWELL_MAX =
    DW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {
    M_OFF,
    M_RED,
    M_GREEN,
    M_ALT
  } mode_t;

  typedef enum logic {
    PH_RED,
    PH_GREEN
  } phase_t;

  // Freeze request; tied off when the hold option is not built.
  logic frz;

`ifdef LED_SEQ_HOLD_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif

  // Prescaler: one-cycle tick every TICK_DIV clocks.
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Two-flop synchronizer for the raw button.
  logic btn_m;
  logic btn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // Debounce: a changed level must persist for DEBOUNCE_TICKS ticks.
  // The press pulse coincides with the tick on which the new high
  // level is accepted, so it can land on a dwell-expiry tick.
  logic          stable;
  logic [BW-1:0] db_cnt;
  logic          db_done;
  logic          press;

  assign db_done = tick
                && (btn_s != stable)
                && (db_cnt == DB_MAX);
  assign press   = db_done && btn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == stable) begin
      db_cnt <= '0;
    end else if (db_done) begin
      stable <= btn_s;
      db_cnt <= '0;
    end else if (tick) begin
      db_cnt <= db_cnt + BW'(1);
    end
  end

  // Mode / phase / dwell state.
  mode_t         mode_q;
  mode_t         mode_d;
  phase_t        ph_q;
  phase_t        ph_d;
  logic [DW-1:0] dw_q;
  logic [DW-1:0] dw_d;
  logic          adv;
  logic          step;

  // A press takes priority over a dwell step on the same tick.
  assign adv  = press && !frz;
  assign step = !adv
             && !frz
             && tick
             && (mode_q == M_ALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= M_OFF;
      ph_q   <= PH_RED;
      dw_q   <= '0;
    end else begin
      mode_q <= mode_d;
      ph_q   <= ph_d;
      dw_q   <= dw_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    ph_d   = ph_q;
    dw_d   = dw_q;
    unique case (1'b1)
      adv: begin
        mode_d = mode_t'(mode_q + 2'd1);
        ph_d   = PH_RED;
        dw_d   = '0;
      end
      step: begin
        if (dw_q == DWELL_MAX) begin
          ph_d = (ph_q == PH_RED) ? PH_GREEN : PH_RED;
          dw_d = '0;
        end else begin
          dw_d = dw_q + DW'(1);
        end
      end
      default: begin
        if (mode_q != M_ALT) begin
          dw_d = '0;
        end
      end
    endcase
  end

  // Output decode from the current mode and phase.
  logic red_d;
  logic green_d;

  always_comb begin
    red_d   = 1'b0;
    green_d = 1'b0;
    unique case (mode_q)
      M_OFF: begin
      end
      M_RED: begin
        red_d = 1'b1;
      end
      M_GREEN: begin
        green_d = 1'b1;
      end
      M_ALT: begin
        red_d   = (ph_q == PH_RED);
        green_d = (ph_q == PH_GREEN);
      end
    endcase
  end

  // Registered enables lag mode/phase by one cycle; mode_l tracks the
  // mode the enables currently reflect so that a mode change pulses
  // change even when the enables themselves do not move.
  mode_t mode_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_en   <= 1'b0;
      green_en <= 1'b0;
      change   <= 1'b0;
      mode_l   <= M_OFF;
    end else if (frz) begin
      change   <= 1'b0;
    end else begin
      red_en   <= red_d;
      green_en <= green_d;
      mode_l   <= mode_q;
      change   <= (mode_l != mode_q)
               || (red_d != red_en)
               || (green_d != green_en);
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer.
// Expected change events are queued with stimulus, popped on change.
module tb_led_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 2;
  localparam int DWELL    = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       btn   = 1'b0;
`ifdef LED_SEQ_HOLD_EN
  logic       hold  = 1'b0;
`endif
  logic       red_en;
  logic       green_en;
  logic       change;
  logic [1:0] mode;

  led_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .DWELL_TICKS   (DWELL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
`ifdef LED_SEQ_HOLD_EN
    .hold    (hold),
`endif
    .red_en  (red_en),
    .green_en(green_en),
    .mode    (mode),
    .change  (change)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         tog;
    logic [1:0] mode;
    logic       red;
    logic       grn;
    int         gap;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  int         n_run     = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         last_chg  = 0;
  int         mode_cyc  = 0;
  logic [1:0] prev_mode = 2'd0;
  bit         both_seen = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic exp_ev(input bit tog, input logic [1:0] m,
                        input logic r, input logic g,
                        input int gap);
    ev_t e;
    e.tog  = tog;
    e.mode = m;
    e.red  = r;
    e.grn  = g;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    repeat (hi) @(negedge clk);
    btn = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic drain(input int left);
    int n;
    n = 0;
    while (sb.size() > left && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'(left));
    if (sb.size() > left) sb.delete();
  endtask

  // Monitor: every change pulse must match the next queued event.
  always @(negedge clk) begin
    cyc++;
    if (red_en === 1'b1 && green_en === 1'b1) both_seen = 1'b1;
    if (change === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spur_chg", 32'(change), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_mode", 32'(mode), 32'(mon_e.mode));
        chk("ev_red", 32'(red_en), 32'(mon_e.red));
        chk("ev_grn", 32'(green_en), 32'(mon_e.grn));
        if (mon_e.gap != 0)
          chk("ev_gap", 32'(cyc - last_chg), 32'(mon_e.gap));
        if (!mon_e.tog)
          chk("ev_lag", 32'(cyc - mode_cyc), 32'd1);
      end
      last_chg = cyc;
    end
    if (mode !== prev_mode) begin
      mode_cyc  = cyc;
      prev_mode = mode;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: sim did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_red", 32'(red_en), 32'd0);
    chk("rst_grn", 32'(green_en), 32'd0);
    chk("rst_chg", 32'(change), 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_mode", 32'(mode), 32'd0);
    chk("idle_red", 32'(red_en), 32'd0);
    chk("idle_grn", 32'(green_en), 32'd0);

    press(3, 40);
    chk("glitch_mode", 32'(mode), 32'd0);

    exp_ev(0, 2'd1, 1, 0, 0);
    exp_ev(0, 2'd2, 0, 1, 40);
    exp_ev(0, 2'd3, 1, 0, 40);
    exp_ev(1, 2'd3, 0, 1, 12);
    exp_ev(1, 2'd3, 1, 0, 12);
    exp_ev(1, 2'd3, 0, 1, 12);
    exp_ev(0, 2'd0, 0, 0, 4);
    repeat (4) press(20, 20);
    drain(0);
    chk("wrap_mode", 32'(mode), 32'd0);
    chk("wrap_red", 32'(red_en), 32'd0);

    exp_ev(0, 2'd1, 1, 0, 0);
    exp_ev(0, 2'd2, 0, 1, 40);
    exp_ev(0, 2'd3, 1, 0, 40);
    exp_ev(1, 2'd3, 0, 1, 12);
    exp_ev(1, 2'd3, 1, 0, 12);
    exp_ev(1, 2'd3, 0, 1, 12);
    exp_ev(1, 2'd3, 1, 0, 12);
    repeat (3) press(20, 20);
    drain(0);
    exp_ev(0, 2'd0, 0, 0, 12);
    repeat (2) @(negedge clk);
    press(20, 20);
    drain(0);
    repeat (40) @(negedge clk);
    chk("coll_mode", 32'(mode), 32'd0);
    chk("coll_grn", 32'(green_en), 32'd0);

    exp_ev(0, 2'd1, 1, 0, 0);
    exp_ev(0, 2'd2, 0, 1, 40);
    exp_ev(0, 2'd3, 1, 0, 40);
    repeat (2) press(20, 20);
    btn = 1'b1;
    drain(0);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_red", 32'(red_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_mode", 32'(mode), 32'd0);
    chk("rm_red", 32'(red_en), 32'd0);
    chk("rm_grn", 32'(green_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rm_idle_red", 32'(red_en), 32'd0);
    chk("rm_idle_grn", 32'(green_en), 32'd0);

    btn   = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_ev(0, 2'd1, 1, 0, 0);
    reset = 1'b0;
    drain(0);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_mode", 32'(mode), 32'd1);

`ifdef LED_SEQ_HOLD_EN
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_ev(0, 2'd1, 1, 0, 0);
    exp_ev(0, 2'd2, 0, 1, 40);
    exp_ev(0, 2'd3, 1, 0, 40);
    exp_ev(1, 2'd3, 0, 1, 52);
    exp_ev(1, 2'd3, 1, 0, 12);
    repeat (2) press(20, 20);
    btn = 1'b1;
    drain(2);
    btn = 1'b0;
    repeat (5) @(negedge clk);
    hold = 1'b1;
    btn  = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_mode", 32'(mode), 32'd3);
    chk("hold_red", 32'(red_en), 32'd1);
    chk("hold_grn", 32'(green_en), 32'd0);
    hold = 1'b0;
    drain(0);
`endif

    chk("excl", 32'(both_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
